// File: rtl/parking_slot_tracker.sv
// parking_slot_tracker: occupancy tracker for a four-slot parking lot.
// Assigns the lowest-index free slot to each arriving car, holds the entry
// gate open for GATE_CYCLES cycles, frees slots on departure reports and
// flags refused entries (lot full) and departures from slots already free.
//
// Interface protocol:
//   arrive_req is a level from the entry sensor. Only its rising edge counts
//   as a new car. An edge seen in IDLE is either granted (slot assigned,
//   gate opened) or refused (denied pulse). An edge seen while the gate is
//   open is dropped silently, so the car must lower and raise arrive_req
//   again to be considered. leave_req is a single-cycle strobe that
//   qualifies leave_slot in the same cycle and is honoured in any state.
//   All decisions in a cycle use the occupancy held at the start of that
//   cycle. A grant and a departure in the same cycle are both applied.
module parking_slot_tracker #(
  parameter int NUM_SLOTS   = 4,
  parameter int GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arrive_req,
  input  logic       leave_req,
  input  logic [1:0] leave_slot,
  output logic [2:0] space_count,
  output logic [1:0] near_slot,
  output logic [3:0] occupied,
  output logic       gate_open,
  output logic [1:0] assigned_slot,
  output logic       denied,
  output logic       leave_err
);

  // Counter reload value. The gate stays open for the load cycle plus
  // CNT_LOAD further cycles, which gives exactly GATE_CYCLES cycles.
  localparam logic [7:0] CNT_LOAD = 8'(GATE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic       gate_next;
  logic       arrive_q;
  logic       arrive_edge;
  logic       grant;
  logic       deny;
  logic       leave_hit;
  logic       leave_miss;
  logic [3:0] occ_next;

  // Rising edge of the entry sensor level: one edge per car presentation.
  assign arrive_edge = arrive_req & ~arrive_q;

  // Free-slot count: number of clear bits in the occupancy register.
  always_comb begin
    space_count = 3'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      space_count = space_count + {2'b00, ~occupied[i]};
    end
  end

  // Nearest free slot: lowest clear bit, 0 when the lot is full.
  always_comb begin
    near_slot = 2'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        near_slot = 2'(i);
      end
    end
  end

  // Gate FSM next state, counter and grant/deny decisions.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    gate_next  = gate_open;
    grant      = 1'b0;
    deny       = 1'b0;
    case (state)
      IDLE: begin
        if (arrive_edge) begin
          if (space_count != 3'd0) begin
            grant      = 1'b1;
            gate_next  = 1'b1;
            cnt_next   = CNT_LOAD;
            state_next = GATE;
          end else begin
            deny = 1'b1;
          end
        end
      end
      GATE: begin
        // Arrival edges are ignored here by construction.
        if (cnt == 8'd0) begin
          gate_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: begin
        gate_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Occupancy update: grant sets a free bit, departure clears a taken bit.
  // The two can never address the same slot because the grant only picks
  // a bit that is currently clear and a valid departure only clears a bit
  // that is currently set.
  always_comb begin
    occ_next   = occupied;
    leave_hit  = leave_req & occupied[leave_slot];
    leave_miss = leave_req & ~occupied[leave_slot];
    if (grant) begin
      occ_next[near_slot] = 1'b1;
    end
    if (leave_hit) begin
      occ_next[leave_slot] = 1'b0;
    end
  end

  // State, counter, occupancy and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      arrive_q      <= 1'b0;
      occupied      <= 4'b0000;
      gate_open     <= 1'b0;
      assigned_slot <= 2'd0;
      denied        <= 1'b0;
      leave_err     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      arrive_q  <= arrive_req;
      occupied  <= occ_next;
      gate_open <= gate_next;
      denied    <= deny;
      leave_err <= leave_miss;
      if (grant) begin
        assigned_slot <= near_slot;
      end
    end
  end

`ifndef SYNTHESIS
  // A refused entry never coincides with an open gate.
  assert property (@(posedge clk) disable iff (rst) denied |-> !gate_open);
  // The gate output tracks the FSM state.
  assert property (@(posedge clk) disable iff (rst) gate_open == (state == GATE));
`endif

endmodule

// File: tb/tb_parking_slot_tracker.sv
// Directed testbench for parking_slot_tracker with hand-computed expectations.
module tb_parking_slot_tracker;

  logic       clk;
  logic       rst;
  logic       arrive_req;
  logic       leave_req;
  logic [1:0] leave_slot;
  logic [2:0] space_count;
  logic [1:0] near_slot;
  logic [3:0] occupied;
  logic       gate_open;
  logic [1:0] assigned_slot;
  logic       denied;
  logic       leave_err;

  int n_checks = 0;
  int n_errors = 0;

  parking_slot_tracker #(.NUM_SLOTS(4), .GATE_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .arrive_req    (arrive_req),
    .leave_req     (leave_req),
    .leave_slot    (leave_slot),
    .space_count   (space_count),
    .near_slot     (near_slot),
    .occupied      (occupied),
    .gate_open     (gate_open),
    .assigned_slot (assigned_slot),
    .denied        (denied),
    .leave_err     (leave_err)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Comparison task: every check goes through here.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_occ(input string tag, input logic [3:0] occ, input logic [2:0] sc,
                           input logic [1:0] ns);
    check({tag, "_occupied"}, 32'(occupied), 32'(occ));
    check({tag, "_space_count"}, 32'(space_count), 32'(sc));
    check({tag, "_near_slot"}, 32'(near_slot), 32'(ns));
  endtask

  // One arrival: arrive_req high 2 cycles, low 6; gate must be high exactly 4 samples.
  task automatic do_arrival(input string tag, input logic [1:0] exp_slot);
    int gate_cnt;
    int deny_cnt;
    gate_cnt = 0;
    deny_cnt = 0;
    arrive_req = 1'b1;
    tick();
    check({tag, "_gate_first"}, 32'(gate_open), 32'd1);
    check({tag, "_assigned"}, 32'(assigned_slot), 32'(exp_slot));
    gate_cnt += int'(gate_open);
    deny_cnt += int'(denied);
    for (int i = 0; i < 7; i++) begin
      if (i == 0) arrive_req = 1'b1;
      else arrive_req = 1'b0;
      tick();
      gate_cnt += int'(gate_open);
      deny_cnt += int'(denied);
    end
    arrive_req = 1'b0;
    check({tag, "_gate_cycles"}, 32'(gate_cnt), 32'd4);
    check({tag, "_no_deny"}, 32'(deny_cnt), 32'd0);
    check({tag, "_gate_closed"}, 32'(gate_open), 32'd0);
  endtask

  task automatic do_leave(input logic [1:0] slot);
    leave_req  = 1'b1;
    leave_slot = slot;
    tick();
    leave_req  = 1'b0;
    leave_slot = 2'd0;
  endtask

  initial begin
    int deny_cnt;
    rst        = 1'b1;
    arrive_req = 1'b0;
    leave_req  = 1'b0;
    leave_slot = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // 1. Reset state
    check_occ("reset", 4'b0000, 3'd4, 2'd0);
    check("reset_gate", 32'(gate_open), 32'd0);
    check("reset_denied", 32'(denied), 32'd0);
    check("reset_leave_err", 32'(leave_err), 32'd0);
    check("reset_assigned", 32'(assigned_slot), 32'd0);

    // 2. Four arrivals fill slots 0..3 in order
    do_arrival("arr0", 2'd0);
    check_occ("after_arr0", 4'b0001, 3'd3, 2'd1);
    do_arrival("arr1", 2'd1);
    check_occ("after_arr1", 4'b0011, 3'd2, 2'd2);
    do_arrival("arr2", 2'd2);
    check_occ("after_arr2", 4'b0111, 3'd1, 2'd3);
    do_arrival("arr3", 2'd3);
    check_occ("full", 4'b1111, 3'd0, 2'd0);

    // 3. Fifth arrival is refused with a single-cycle denied pulse
    deny_cnt = 0;
    arrive_req = 1'b1;
    tick();
    check("full_denied", 32'(denied), 32'd1);
    check("full_gate", 32'(gate_open), 32'd0);
    deny_cnt += int'(denied);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) arrive_req = 1'b0;
      tick();
      deny_cnt += int'(denied);
    end
    check("full_deny_pulses", 32'(deny_cnt), 32'd1);
    check("full_gate_after", 32'(gate_open), 32'd0);
    check_occ("full_after_deny", 4'b1111, 3'd0, 2'd0);

    // 3b. Arrival while full with a leave in the same cycle: still refused
    arrive_req = 1'b1;
    leave_req  = 1'b1;
    leave_slot = 2'd1;
    tick();
    leave_req  = 1'b0;
    check("arr_leave_denied", 32'(denied), 32'd1);
    check("arr_leave_gate", 32'(gate_open), 32'd0);
    check_occ("arr_leave", 4'b1101, 3'd1, 2'd1);
    arrive_req = 1'b0;
    tick();
    check("arr_leave_deny_drop", 32'(denied), 32'd0);

    // 4. Freed slot 1 is assigned to the next car
    do_arrival("reuse1", 2'd1);
    check_occ("reuse1_full", 4'b1111, 3'd0, 2'd0);
    do_leave(2'd1);
    check_occ("leave1", 4'b1101, 3'd1, 2'd1);
    do_arrival("reuse1b", 2'd1);
    check_occ("reuse1b_full", 4'b1111, 3'd0, 2'd0);

    // 5. Departure from an already free slot
    do_leave(2'd2);
    check_occ("leave2", 4'b1011, 3'd1, 2'd2);
    do_leave(2'd2);
    check("bogus_leave_err", 32'(leave_err), 32'd1);
    check_occ("bogus_leave", 4'b1011, 3'd1, 2'd2);
    tick();
    check("bogus_leave_err_drop", 32'(leave_err), 32'd0);
    // Bogus departure in the same cycle as a grant
    arrive_req = 1'b1;
    leave_req  = 1'b1;
    leave_slot = 2'd2;
    tick();
    leave_req  = 1'b0;
    check("grant_err_leave_err", 32'(leave_err), 32'd1);
    check("grant_err_gate", 32'(gate_open), 32'd1);
    check("grant_err_assigned", 32'(assigned_slot), 32'd2);
    check_occ("grant_err", 4'b1111, 3'd0, 2'd0);
    arrive_req = 1'b0;
    tick();
    check("grant_err_leave_err_drop", 32'(leave_err), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("grant_err_gate_closed", 32'(gate_open), 32'd0);

    // 6. Second arrival edge during an open gate is ignored
    do_leave(2'd0);
    do_leave(2'd3);
    check_occ("two_free", 4'b0110, 3'd2, 2'd0);
    arrive_req = 1'b1;
    tick();
    check("gate_ign_assigned", 32'(assigned_slot), 32'd0);
    arrive_req = 1'b0;
    tick();
    arrive_req = 1'b1;
    tick();
    check("gate_ign_denied", 32'(denied), 32'd0);
    check("gate_ign_assigned2", 32'(assigned_slot), 32'd0);
    check_occ("gate_ign", 4'b0111, 3'd1, 2'd3);
    arrive_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("gate_ign_closed", 32'(gate_open), 32'd0);
    check_occ("gate_ign_after", 4'b0111, 3'd1, 2'd3);

    // Reset in the middle of an open gate
    arrive_req = 1'b1;
    tick();
    check("mid_gate_open", 32'(gate_open), 32'd1);
    check("mid_gate_assigned", 32'(assigned_slot), 32'd3);
    arrive_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_gate", 32'(gate_open), 32'd0);
    check("mid_rst_assigned", 32'(assigned_slot), 32'd0);
    check_occ("mid_rst", 4'b0000, 3'd4, 2'd0);
    tick();
    check("post_rst_gate", 32'(gate_open), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_slot_tracker.md
Name: parking_slot_tracker

Overview:
Slot-occupancy controller that produces the space_count / near_slot pair consumed by the lot's seven-segment display driver. It tracks occupancy of NUM_SLOTS parking slots, assigns the nearest free slot (lowest index) to each arriving car, and opens the entry gate for a fixed time. It also frees slots on departure reports and flags denied entries and bogus departures. It sits between the gate/slot sensors and the display driver.

Parameters:
NUM_SLOTS, 4, number of slots; fixed at 4 (near_slot 2 bits, space_count 3 bits)
GATE_CYCLES, 4, clock cycles gate_open stays high per granted entry; legal range 1..255

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
arrive_req  in  1  entry sensor level; a car is present at the gate while high
leave_req  in  1  single-cycle pulse: a car has left slot leave_slot
leave_slot  in  2  slot index qualified by leave_req
space_count  out  3  number of free slots, 0..4
near_slot  out  2  lowest-index free slot; 0 when space_count==0
occupied  out  4  per-slot occupancy register, bit i = slot i taken
gate_open  out  1  entry gate open command
assigned_slot  out  2  slot granted to the most recent admitted car
denied  out  1  one-cycle pulse: entry refused, lot full
leave_err  out  1  one-cycle pulse: leave_req named a slot that is already free

Behaviour:
- Reset (rst high at a clk edge): occupied=0000, gate_open=0, assigned_slot=0, denied=0, leave_err=0, state=IDLE, gate counter=0, arrive_q=0. Resulting space_count=4, near_slot=0. Reset overrides all inputs and aborts an open gate immediately.
- space_count = number of zero bits in occupied. near_slot = index of the lowest zero bit, or 0 if none. Both are combinational from the occupied register and reflect an update one cycle after the causing edge.
- Arrival edge detection: arrive_q registers arrive_req every cycle. arrive_edge = arrive_req & ~arrive_q. A held-high arrive_req produces exactly one edge.
- FSM states: IDLE, GATE.
  - IDLE, arrive_edge, space_count!=0: at that edge occupied[near_slot]<=1, assigned_slot<=near_slot, gate_open<=1, cnt<=GATE_CYCLES-1, go to GATE.
  - IDLE, arrive_edge, space_count==0: denied<=1 for one cycle, stay IDLE, occupancy unchanged.
  - GATE: if cnt==0 then gate_open<=0 and go to IDLE, else cnt<=cnt-1. gate_open is high for exactly GATE_CYCLES cycles.
  - arrive_edge seen in GATE is discarded: no grant, no denied. A car must re-present by dropping and re-raising arrive_req.
- Departure (any state): when leave_req is high and occupied[leave_slot]==1, clear that bit. When leave_req is high and the bit is already 0, occupancy is unchanged and leave_err<=1 for one cycle.
- Simultaneous grant and leave in one cycle: both applied. The grant uses near_slot/space_count from the pre-update occupancy, so they can never target the same slot.
- Arrival when full with a leave in the same cycle: denied, because the decision uses pre-update occupancy. The slot freed by the leave is visible from the next cycle.
- denied and leave_err default to 0 every cycle unless set as above.
- No wrap-around: space_count is bounded 0..4 by construction.

Test Plan:
1. Reset, then idle 3 cycles -> occupied=0000, space_count=4, near_slot=0, gate_open=0, denied=0.
2. Four arrivals (arrive_req high 2 cycles, low 6), GATE_CYCLES=4 -> assigned_slot 0,1,2,3 in order; gate_open high exactly 4 cycles each; final occupied=1111, space_count=0, near_slot=0.
3. Lot full, fifth arrival -> denied high for exactly 1 cycle, gate_open stays 0, occupied=1111.
4. From 1111, leave_req with leave_slot=1, then an arrival -> occupied=1101, space_count=1, near_slot=1; the arrival gets assigned_slot=1 and occupied returns to 1111.
5. leave_req with leave_slot=2 while occupied=1011 -> leave_err one-cycle pulse, occupied unchanged; same cycle as a grant -> grant still completes normally.
6. A second arrive_req rising edge 2 cycles into an open gate -> ignored (no grant, no denied). Assert rst in the middle of a gate -> gate_open=0 and occupied=0000 on the next cycle.
